// File: rtl/float_divider_e4m3_if.sv
// Request/result bundle for the sequential E4M3 divider.
// The master drives the operands and start; the slave returns ready, y and the valid pulse.
interface float_divider_e4m3_if;
    logic [7:0] a;
    logic [7:0] b;
    logic       start;
    logic       ready;
    logic [7:0] y;
    logic       is_output_valid;

    modport master (output a, b, start, input ready, y, is_output_valid);
    modport slave  (input a, b, start, output ready, y, is_output_valid);
endinterface

// File: rtl/float_divider_e4m3.sv
// Sequential E4M3 divider y = a / b: restoring mantissa division (one quotient bit per cycle)
// followed by a single normalise/round/pack cycle. Latency is fixed for every operand pair.
module float_divider_e4m3 #(
    parameter int BIAS   = 7,
    parameter int Q_BITS = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    float_divider_e4m3_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

    state_t      state_q;
    logic [7:0]  a_q, b_q;
    logic [4:0]  rem_q;
    logic [5:0]  q_q;
    logic [2:0]  cnt_q;
    logic [7:0]  y_q;
    logic        valid_q;
    logic        ready_q;

    // Restoring step: the remainder always stays below 2*mb, so 5 bits suffice.
    logic [4:0]  mb_ext;
    logic        ge;
    logic [4:0]  rem_sub;

    assign mb_ext  = {2'b01, b_q[2:0]};
    assign ge      = (rem_q >= mb_ext);
    assign rem_sub = ge ? (rem_q - mb_ext) : rem_q;

    logic              sign;
    logic              a_nan, b_nan, a_zero, b_zero;
    logic signed [6:0] e_d;
    logic [2:0]        m_d;
    logic              g_d, s_d, up_d;
    logic [6:0]        mag_d;
    logic [7:0]        res_d;

    assign sign   = a_q[7] ^ b_q[7];
    assign a_nan  = (a_q[6:0] == 7'h7F);
    assign b_nan  = (b_q[6:0] == 7'h7F);
    assign a_zero = (a_q[6:3] == 4'd0);
    assign b_zero = (b_q[6:3] == 4'd0);

    always_comb begin
        e_d = $signed({3'b000, a_q[6:3]}) - $signed({3'b000, b_q[6:3]}) + $signed(7'(BIAS));
        if (q_q[5]) begin
            m_d = q_q[4:2];
            g_d = q_q[1];
            s_d = q_q[0] | (rem_q != 5'd0);
        end else begin
            // Quotient below 1.0: q[4] is then guaranteed set, so shift by one and adjust exponent.
            m_d = q_q[3:1];
            g_d = q_q[0];
            s_d = (rem_q != 5'd0);
            e_d = e_d - 7'sd1;
        end
        up_d = g_d & (s_d | m_d[0]);
        if (up_d) begin
            if (m_d == 3'b111) begin
                m_d = 3'b000;
                e_d = e_d + 7'sd1;
            end else begin
                m_d = m_d + 3'd1;
            end
        end
        if ((e_d > 7'sd15) || ((e_d == 7'sd15) && (m_d == 3'b111))) begin
            mag_d = 7'h7E;
        end else if (e_d < 7'sd1) begin
            mag_d = 7'h00;
        end else begin
            mag_d = {e_d[3:0], m_d};
        end
        if (a_nan || b_nan || b_zero) begin
            res_d = {sign, 7'h7F};
        end else if (a_zero) begin
            res_d = {sign, 7'h00};
        end else begin
            res_d = {sign, mag_d};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            rem_q   <= 5'd0;
            q_q     <= 6'd0;
            cnt_q   <= 3'd0;
            y_q     <= 8'h00;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        rem_q   <= {2'b01, bus.a[2:0]};
                        q_q     <= 6'd0;
                        cnt_q   <= 3'd0;
                        ready_q <= 1'b0;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    q_q   <= {q_q[4:0], ge};
                    rem_q <= {rem_sub[3:0], 1'b0};
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'(Q_BITS - 1)) begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    y_q     <= res_d;
                    valid_q <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.y               = y_q;
    assign bus.is_output_valid = valid_q;
    assign bus.ready           = ready_q;
endmodule
